// File: rtl/gate_sweep_sequencer.sv
// Gate datapath self-test sequencer: walks every enabled gate code
// through all four {b,a} vectors, captures y and checks it against
// a golden truth table.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   start, abort       sweep request / cancel
//   gate_mask[6:0]     enable per gate code (code 7 never swept)
//   dut_a/b, dut_sel   drive to gate datapath; dut_y back from it
//   busy, done, pass   sweep status (done is a 1-cycle pulse)
//   err_cnt, fail_*    mismatch count and first-mismatch location
//   tbl[27:0]          captured truth table, bit 4*code+{b,a}
module gate_sweep_sequencer #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  gate_mask,
    output logic        dut_a,
    output logic        dut_b,
    output logic [2:0]  dut_sel,
    input  logic        dut_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic        fail_vld,
    output logic [2:0]  fail_sel,
    output logic [1:0]  fail_ab,
    output logic [27:0] tbl
);

    localparam logic [7:0] T_LAST = 8'(STEP_DIV - 1);
    localparam logic [7:0] T_SMPL = 8'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  ab_q, ab_d;
    logic [2:0]  sel_q, sel_d;
    logic        busy_d, done_d, pass_d;
    logic [4:0]  err_d;
    logic        fvld_d;
    logic [2:0]  fsel_d;
    logic [1:0]  fab_d;
    logic [27:0] tbl_d;

    logic [2:0]  first_code, next_code;
    logic        has_next;
    logic        go;
    logic        sample, vec_end, last_vec;

    // Expected y for a gate code, as a nibble indexed by {b,a}.
    function automatic logic golden(input logic [2:0] s,
                                    input logic [1:0] ab);
        logic [3:0] nib;
        case (s)
            3'd0:    nib = 4'h8;
            3'd1:    nib = 4'hE;
            3'd2:    nib = 4'h5;
            3'd3:    nib = 4'h7;
            3'd4:    nib = 4'h1;
            3'd5:    nib = 4'h6;
            3'd6:    nib = 4'h9;
            default: nib = 4'h0;
        endcase
        return nib[ab];
    endfunction

    // Lowest enabled code overall, and lowest enabled code above the
    // one being swept (scanned downward so the lowest match wins).
    always_comb begin
        first_code = 3'd0;
        next_code  = 3'd0;
        has_next   = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (gate_mask[i]) begin
                first_code = 3'(i);
            end
            if (gate_mask[i] && (i > int'(sel_q))) begin
                next_code = 3'(i);
                has_next  = 1'b1;
            end
        end
    end

    assign go       = start && !abort;
    assign sample   = (state_q == RUN) && (timer_q == T_SMPL);
    assign vec_end  = (state_q == RUN) && (timer_q == T_LAST);
    assign last_vec = vec_end && (ab_q == 2'd3) && !has_next;

    // State register plus the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            ab_q     <= '0;
            sel_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_sel <= '0;
            fail_ab  <= '0;
            tbl      <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ab_q     <= ab_d;
            sel_q    <= sel_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_d;
            fail_vld <= fvld_d;
            fail_sel <= fsel_d;
            fail_ab  <= fab_d;
            tbl      <= tbl_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = (gate_mask != 7'd0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_vec) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and sweep counters.
    always_comb begin
        timer_d = timer_q;
        ab_d    = ab_q;
        sel_d   = sel_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_cnt;
        fvld_d  = fail_vld;
        fsel_d  = fail_sel;
        fab_d   = fail_ab;
        tbl_d   = tbl;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    err_d   = '0;
                    fvld_d  = 1'b0;
                    fsel_d  = '0;
                    fab_d   = '0;
                    tbl_d   = '0;
                    timer_d = '0;
                    ab_d    = '0;
                    if (gate_mask != 7'd0) begin
                        pass_d = 1'b0;
                        busy_d = 1'b1;
                        sel_d  = first_code;
                    end else begin
                        pass_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Partial results stay visible; only pass is forced.
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    timer_d = '0;
                    ab_d    = '0;
                    sel_d   = '0;
                end else begin
                    if (sample) begin
                        tbl_d[{sel_q, ab_q}] = dut_y;
                        if (dut_y != golden(sel_q, ab_q)) begin
                            err_d = err_cnt + 5'd1;
                            if (!fail_vld) begin
                                fvld_d = 1'b1;
                                fsel_d = sel_q;
                                fab_d  = ab_q;
                            end
                        end
                    end
                    if (vec_end) begin
                        timer_d = '0;
                        if (ab_q != 2'd3) begin
                            ab_d = ab_q + 2'd1;
                        end else if (has_next) begin
                            ab_d  = '0;
                            sel_d = next_code;
                        end else begin
                            // err_d covers a sample on this same edge.
                            ab_d   = '0;
                            sel_d  = '0;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            pass_d = (err_d == 5'd0);
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            FIN: begin
                done_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign dut_a   = ab_q[0];
    assign dut_b   = ab_q[1];
    assign dut_sel = sel_q;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Directed bench for gate_sweep_sequencer with a behavioural gate
// datapath, a result scoreboard queue and immediate-assertion checks.
module tb_gate_sweep_sequencer;

    localparam int S  = 4;
    localparam int ST = 1;

    typedef struct {
        logic [27:0] tbl;
        logic [4:0]  err;
        logic        pass;
        logic        fv;
        logic [2:0]  fs;
        logic [1:0]  fab;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  gate_mask;
    logic        dut_a, dut_b;
    logic [2:0]  dut_sel;
    logic        dut_y;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic        fail_vld;
    logic [2:0]  fail_sel;
    logic [1:0]  fail_ab;
    logic [27:0] tbl;

    logic        stuck0 = 1'b0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    gate_sweep_sequencer #(.STEP_DIV(S), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_mask(gate_mask), .dut_a(dut_a), .dut_b(dut_b),
        .dut_sel(dut_sel), .dut_y(dut_y), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_vld(fail_vld),
        .fail_sel(fail_sel), .fail_ab(fail_ab), .tbl(tbl)
    );

    always #5 clk = ~clk;

    function automatic logic gate(input logic [2:0] c,
                                  input logic a, input logic b);
        case (c)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural datapath, optionally stuck at 0.
    always_comb dut_y = stuck0 ? 1'b0 : gate(dut_sel, dut_a, dut_b);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected results of a sweep; samples at or after abort_at
    // cycle are not taken (abort_at < 0 means no abort).
    task automatic model(input logic [6:0] mask, input logic flt,
                         input int abort_at, output exp_t e);
        int v = 0;
        e.tbl = '0; e.err = '0; e.fv = 1'b0; e.fs = '0; e.fab = '0;
        for (int c = 0; c < 7; c++) begin
            if (mask[c]) begin
                for (int ab = 0; ab < 4; ab++) begin
                    logic t, y;
                    int   sc;
                    sc = 1 + v * S + ST;
                    t  = gate(3'(c), ab[0], ab[1]);
                    y  = flt ? 1'b0 : t;
                    if (abort_at < 0 || sc < abort_at) begin
                        e.tbl[4 * c + ab] = y;
                        if (y != t) begin
                            e.err++;
                            if (!e.fv) begin
                                e.fv = 1'b1;
                                e.fs = 3'(c);
                                e.fab = 2'(ab);
                            end
                        end
                    end
                    v++;
                end
            end
        end
        e.pass = (abort_at < 0) && (e.err == 0);
    endtask

    task automatic sweep(input string tag, input logic [6:0] mask,
                         input logic flt, input logic hold,
                         input int abort_at);
        exp_t e, got;
        int   codes[$];
        int   n, last, busy_bad, vec_bad, done_cnt, done_c;
        bit   want_done;
        for (int i = 0; i < 7; i++) if (mask[i]) codes.push_back(i);
        n         = codes.size();
        last      = 4 * n * S;
        want_done = (abort_at < 0);
        busy_bad  = 0; vec_bad = 0; done_cnt = 0; done_c = -1;
        stuck0    = flt;
        model(mask, flt, abort_at, e);
        if (want_done) sb.push_back(e);
        gate_mask = mask;
        start     = 1'b1;
        abort     = 1'b0;
        tick();
        for (int c = 1; c <= last + 4; c++) begin
            logic eb;
            eb = want_done ? (c <= last) : (c <= abort_at);
            if (busy !== eb) busy_bad++;
            if (busy === 1'b1) begin
                int v, k;
                v = (c - 1) / S;
                k = v / 4;
                if (k >= n || dut_sel !== 3'(codes[k]) ||
                    dut_a !== v[0] || dut_b !== v[1]) vec_bad++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_c = c;
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk({tag, "_tbl"}, 32'(tbl), 32'(got.tbl));
                    chk({tag, "_err"}, 32'(err_cnt), 32'(got.err));
                    chk({tag, "_pass"}, 32'(pass), 32'(got.pass));
                    chk({tag, "_fvld"}, 32'(fail_vld), 32'(got.fv));
                    chk({tag, "_fsel"}, 32'(fail_sel), 32'(got.fs));
                    chk({tag, "_fab"}, 32'(fail_ab), 32'(got.fab));
                end
            end
            start = hold && (c < last);
            abort = (c == abort_at);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_vec"}, 32'(vec_bad), 32'd0);
        chk({tag, "_ndone"}, 32'(done_cnt), want_done ? 32'd1 : 32'd0);
        if (want_done) begin
            chk({tag, "_done_cyc"}, 32'(done_c), 32'(last + 1));
        end else begin
            chk({tag, "_ab_pass"}, 32'(pass), 32'd0);
            chk({tag, "_ab_tbl"}, 32'(tbl), 32'(e.tbl));
            chk({tag, "_ab_err"}, 32'(err_cnt), 32'(e.err));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; gate_mask = '0;
        tick();
        tick();
        chk("rst_out", {13'd0, busy, done, pass, err_cnt, fail_vld,
                        fail_sel, fail_ab, dut_a, dut_b, dut_sel}, 32'd0);
        chk("rst_tbl", 32'(tbl), 32'd0);
        rst = 1'b0;
        tick();

        sweep("full", 7'h7F, 1'b0, 1'b0, -1);
        sweep("stuck", 7'h7F, 1'b1, 1'b0, -1);
        sweep("xor", 7'b0100000, 1'b0, 1'b0, -1);
        sweep("sparse", 7'b1010010, 1'b1, 1'b0, -1);
        sweep("abort", 7'h7F, 1'b0, 1'b0, 20);
        sweep("fresh", 7'h7F, 1'b0, 1'b0, -1);
        sweep("mask0", 7'h00, 1'b0, 1'b0, -1);
        sweep("hold", 7'h7F, 1'b0, 1'b1, -1);

        // Reset mid-sweep, with a start in the reset cycle.
        gate_mask = 7'h7F;
        stuck0    = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 50; c++) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk("rst_mid_out", {13'd0, busy, done, pass, err_cnt, fail_vld,
                            fail_sel, fail_ab, dut_a, dut_b, dut_sel},
            32'd0);
        chk("rst_mid_tbl", 32'(tbl), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_idle", {30'd0, busy, done}, 32'd0);
        tick();
        chk("rst_idle2", {30'd0, busy, done}, 32'd0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_sequencer.md
# gate_sweep_sequencer

Self-test sequencer for the trainer's combinational gate datapath (a, b, 3-bit gate select, single output y). When started, it walks every enabled gate code through all four input combinations and samples the returned y. It builds the captured truth table and compares each sample against a built-in golden model. The block sits between the top-level control inputs and the gate datapath, and drives the datapath's a/b/sel in place of the manual switches while busy.

## Interface

Parameters:
- STEP_DIV, 4: clock cycles spent on each input vector; legal range 2..255.
- SETTLE, 1: cycle index within a vector at which dut_y is sampled; legal range 0..STEP_DIV-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; honoured only in IDLE.
- abort  in  1  cancel a sweep in progress.
- gate_mask  in  7  bit i enables gate code i (0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR); code 7 is never swept.
- dut_a, dut_b  out  1 each  datapath operands.
- dut_sel  out  3  datapath gate select.
- dut_y  in  1  datapath result (combinational from dut_a/b/sel).
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  held; 1 when the last completed sweep had zero mismatches.
- err_cnt  out  5  mismatch count of the current or last sweep (max 28).
- fail_vld  out  1  a mismatch has been recorded in this sweep.
- fail_sel  out  3  gate code of the first mismatch.
- fail_ab  out  2  {b,a} of the first mismatch.
- tbl  out  28  captured truth table; bit 4*code+{b,a} holds the sampled y.

## Operation

- States:
  - IDLE: dut_a, dut_b and dut_sel are driven 0.
  - RUN.
  - FIN.
- IDLE to RUN on start=1 with abort=0 and gate_mask≠0. On entry:
  - Clear err_cnt, fail_*, pass and the whole of tbl.
  - Load the lowest enabled code into dut_sel, set ab=00 and timer=0.
- IDLE to FIN on start=1 with abort=0 and gate_mask=0. Nothing is swept; pass ends at 1 and err_cnt at 0.
- RUN:
  - timer counts 0..STEP_DIV-1.
  - When timer==SETTLE:
    - Write dut_y into tbl[4*sel+ab].
    - Compare dut_y against the golden value.
    - On mismatch, increment err_cnt. If fail_vld=0, also latch fail_sel and fail_ab and set fail_vld.
  - When timer==STEP_DIV-1: timer returns to 0 and ab increments in the order 00, 01, 10, 11 (dut_a=ab[0], dut_b=ab[1]).
  - After ab=11, dut_sel moves to the next higher enabled code and ab returns to 00.
  - When no higher enabled code remains, go to FIN.
- FIN lasts one cycle: done=1, pass=(err_cnt==0). Then go to IDLE.
- Golden model, as a 4-bit nibble indexed by {b,a}:
  - AND 8, OR E, NOT 5, NAND 7, NOR 1, XOR 6, XNOR 9.
- abort=1 in RUN: go to IDLE on the next edge.
  - No done pulse; pass is forced to 0.
  - tbl, err_cnt and fail_* keep their partial values.
- abort is ignored in FIN and in IDLE. In IDLE, an abort together with start suppresses the start.
- start is ignored in RUN and FIN.
- gate_mask is sampled continuously. Changing it mid-sweep affects only the choice of the next gate; the gate currently being swept always completes.

## Timing

- Reset: every output is 0 (busy, done, pass, err_cnt, fail_vld, fail_sel, fail_ab, tbl, dut_*); state is IDLE.
- Reset wins over start and abort. Reset during RUN returns to IDLE on the next edge with all outputs 0.
- All outputs are registered.
- Cycle numbering: start is sampled high at the edge ending cycle 0, and N is the number of enabled gates.
  - busy is high for cycles 1..4·N·STEP_DIV.
  - done is high in cycle 4·N·STEP_DIV+1.
  - pass and err_cnt are final in that same cycle.
- The vector for index v is driven for cycles 1+v·STEP_DIV .. (v+1)·STEP_DIV.
- dut_y is sampled at cycle 1+v·STEP_DIV+SETTLE.
- With gate_mask=0, done is high in cycle 1.
- err_cnt never exceeds 28, so no saturation logic is required.

## Test plan

- Healthy datapath, gate_mask=7F, STEP_DIV=4, SETTLE=1, start in cycle 0 -> busy over cycles 1..112, done in cycle 113, tbl=28'h96175E8, err_cnt=0, pass=1, fail_vld=0.
- dut_y stuck at 0, gate_mask=7F -> tbl=0, err_cnt=14, fail_vld=1, fail_sel=0, fail_ab=3, pass=0.
- gate_mask=7'b0100000 (XOR only) -> dut_sel=5 throughout busy, done in cycle 17, tbl=28'h0600000, pass=1.
- abort asserted in cycle 20 of a full sweep -> busy low from cycle 21, no done pulse, pass=0. A fresh start then gives tbl=28'h96175E8 and pass=1.
- gate_mask=0 with start -> done in cycle 1, busy never high, pass=1, err_cnt=0. Also: start held high during RUN causes no restart and no extra done.
- rst asserted in cycle 50, then released -> all outputs 0 on the next cycle. A start asserted in the same cycle as rst is ignored, and the block stays IDLE.
